// File: rtl/gather_queue_if.sv
// Bundle of the enqueue, read-window and status signals of gather_queue.
// The slave modport is the queue itself; the master modport is the
// producer/consumer side that drives entries in and retires them.
interface gather_queue_if #(
    parameter int DATA  = 32,
    parameter int WIN   = 4,
    parameter int ROUT  = 4,
    parameter int DEPTH = 16
);
    logic [WIN-1:0]                  in_valid;
    logic [WIN-1:0][DATA-1:0]        in_data;
    logic                            in_ready;
    logic [ROUT-1:0]                 out_valid;
    logic [ROUT-1:0][DATA-1:0]       out_data;
    logic [$clog2(ROUT+1)-1:0]       deq_cnt;
    logic [$clog2(DEPTH+1)-1:0]      count;
    logic                            full;
    logic                            empty;

    modport master (
        output in_valid, in_data, deq_cnt,
        input  in_ready, out_valid, out_data, count, full, empty
    );

    modport slave (
        input  in_valid, in_data, deq_cnt,
        output in_ready, out_valid, out_data, count, full, empty
    );
endinterface

// File: rtl/gather_queue.sv
// Multi-port FIFO behind the gather compaction stage. Accepts up to WIN
// contiguous entries per cycle, presents the oldest ROUT entries in parallel
// and retires a clamped, variable number of them per cycle.
module gather_queue #(
    parameter int DATA  = 32,
    parameter int WIN   = 4,
    parameter int ROUT  = 4,
    parameter int DEPTH = 16,
    parameter bit ACT   = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    gather_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(WIN + 1);

    logic [DATA-1:0] mem_q [DEPTH];
    logic [DATA-1:0] mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [WIN-1:0]  vld_s;
    logic            run_s;
    logic [NW-1:0]   n_in_s;
    logic [NW-1:0]   n_acc_s;
    logic            ready_s;
    logic [CW-1:0]   deq_lim_s;
    logic [CW-1:0]   n_out_s;

    // Length of the leading run of active valid slots; anything after a gap is dropped.
    always_comb begin
        vld_s  = ACT ? bus.in_valid : ~bus.in_valid;
        n_in_s = {NW{1'b0}};
        run_s  = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            if (run_s && vld_s[i]) begin
                n_in_s = n_in_s + NW'(1);
            end else begin
                run_s = 1'b0;
            end
        end
    end

    // Acceptance depends only on registered occupancy, never on the same-cycle dequeue.
    always_comb begin
        ready_s = ((CW'(DEPTH) - count_q) >= CW'(WIN));
        n_acc_s = ready_s ? n_in_s : {NW{1'b0}};
    end

    // Retire count is the request clamped to the window width and to the occupancy.
    always_comb begin
        if (CW'(bus.deq_cnt) > CW'(ROUT)) begin
            deq_lim_s = CW'(ROUT);
        end else begin
            deq_lim_s = CW'(bus.deq_cnt);
        end
        if (deq_lim_s > count_q) begin
            n_out_s = count_q;
        end else begin
            n_out_s = deq_lim_s;
        end
    end

    // Next-state for storage and pointers; flush wins over enqueue and dequeue.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            for (int i = 0; i < WIN; i++) begin
                mem_d[tail_q + PW'(i)] = (NW'(i) < n_acc_s) ? bus.in_data[i]
                                                             : mem_q[tail_q + PW'(i)];
            end
            tail_d  = tail_q + PW'(n_acc_s);
            head_d  = head_q + PW'(n_out_s);
            count_d = count_q + CW'(n_acc_s) - n_out_s;
        end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read window and status flags decoded from registered state only.
    always_comb begin
        for (int i = 0; i < ROUT; i++) begin
            bus.out_data[i]  = mem_q[head_q + PW'(i)];
            bus.out_valid[i] = (CW'(i) < count_q) ? ACT : ~ACT;
        end
        bus.count    = count_q;
        bus.full     = (count_q == CW'(DEPTH)) ? ACT : ~ACT;
        bus.empty    = (count_q == {CW{1'b0}}) ? ACT : ~ACT;
        bus.in_ready = ready_s ? ACT : ~ACT;
    end
endmodule

// File: tb/tb_gather_queue.sv
// Self-checking bench for gather_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_gather_queue;
    localparam int DATA  = 32;
    localparam int WIN   = 4;
    localparam int ROUT  = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    gather_queue_if #(.DATA(DATA), .WIN(WIN), .ROUT(ROUT), .DEPTH(DEPTH)) bus ();

    gather_queue #(.DATA(DATA), .WIN(WIN), .ROUT(ROUT), .DEPTH(DEPTH), .ACT(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA-1:0] mdl[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIN-1:0][DATA-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                                     input logic [31:0] c, input logic [31:0] e);
        mk = {e, c, b, a};
    endfunction

    // Compare every visible output against the reference queue.
    task automatic check_state(input string tag);
        int sz;
        logic [ROUT-1:0] ev;
        sz = mdl.size();
        ev = '0;
        for (int i = 0; i < ROUT; i++) if (i < sz) ev[i] = 1'b1;
        chk({tag, ".count"}, 32'(bus.count), 32'(sz));
        chk({tag, ".ready"}, 32'(bus.in_ready), 32'((DEPTH - sz) >= WIN));
        chk({tag, ".full"},  32'(bus.full),  32'(sz == DEPTH));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(sz == 0));
        chk({tag, ".ovld"},  32'(bus.out_valid), 32'(ev));
        for (int i = 0; i < ROUT; i++) begin
            if (i < sz) chk({tag, ".data"}, bus.out_data[i], mdl[i]);
        end
    endtask

    // Apply one cycle of stimulus, advance the model by the queue rules, then check.
    task automatic cycle(input logic [WIN-1:0] v, input logic [WIN-1:0][DATA-1:0] d,
                         input int deq, input logic fl, input string tag);
        int n_in;
        int n_out;
        bit run;
        bit rdy;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.deq_cnt  = 3'(deq);
        flush        = fl;
        n_in = 0;
        run  = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            if (run && v[i]) n_in++;
            else run = 1'b0;
        end
        rdy   = (DEPTH - mdl.size()) >= WIN;
        n_out = deq;
        if (n_out > ROUT) n_out = ROUT;
        if (n_out > mdl.size()) n_out = mdl.size();
        @(posedge clk);
        #1;
        if (fl) begin
            mdl.delete();
        end else begin
            repeat (n_out) void'(mdl.pop_front());
            if (rdy) for (int i = 0; i < n_in; i++) mdl.push_back(d[i]);
        end
        check_state(tag);
    endtask

    task automatic enq4(input logic [31:0] base, input string tag);
        cycle(4'hF, mk(base, base + 32'd1, base + 32'd2, base + 32'd3), 0, 1'b0, tag);
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.deq_cnt  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single two-entry enqueue
        cycle(4'b0011, mk(32'hAAAA_0000, 32'hBBBB_0000, 32'h0, 32'h0), 0, 1'b0, "enq2");
        chk("enq2.a", bus.out_data[0], 32'hAAAA_0000);
        chk("enq2.b", bus.out_data[1], 32'hBBBB_0000);

        // Fill to full, then a single dequeue keeps ready low
        cycle(4'h0, '0, 0, 1'b1, "fl0");
        for (int k = 0; k < 4; k++) enq4(32'h100 + 32'(k * 4), "fill");
        chk("fill.full",  32'(bus.full), 32'd1);
        chk("fill.rdy",   32'(bus.in_ready), 32'd0);
        cycle(4'h0, '0, 1, 1'b0, "deq1");
        chk("deq1.cnt",   32'(bus.count), 32'd15);
        chk("deq1.rdy",   32'(bus.in_ready), 32'd0);

        // Build head=14, count=4 then enqueue 3 with dequeue 2 across the wrap
        cycle(4'h0, '0, 0, 1'b1, "fl1");
        for (int k = 0; k < 3; k++) enq4(32'h200 + 32'(k * 4), "w_fill");
        for (int k = 0; k < 3; k++) cycle(4'h0, '0, 4, 1'b0, "w_drain");
        cycle(4'b0011, mk(32'h58, 32'h59, 32'h0, 32'h0), 0, 1'b0, "w_xy");
        cycle(4'hF, mk(32'h50, 32'h51, 32'h52, 32'h53), 2, 1'b0, "w_pqrs");
        cycle(4'b0111, mk(32'h60, 32'h61, 32'h62, 32'h0), 2, 1'b0, "w_mix");
        chk("wrap.cnt", 32'(bus.count), 32'd5);
        chk("wrap.d0",  bus.out_data[0], 32'h52);
        chk("wrap.d1",  bus.out_data[1], 32'h53);
        chk("wrap.d2",  bus.out_data[2], 32'h60);

        // Gap in valid pattern and over-requested dequeue
        cycle(4'h0, '0, 0, 1'b1, "fl2");
        cycle(4'b1101, mk(32'h70, 32'h71, 32'h72, 32'h73), 0, 1'b0, "gap");
        chk("gap.cnt", 32'(bus.count), 32'd1);
        cycle(4'h0, '0, 4, 1'b0, "clamp");
        chk("clamp.empty", 32'(bus.empty), 32'd1);

        // Flush beats simultaneous enqueue and dequeue
        enq4(32'h300, "f_a");
        cycle(4'b0011, mk(32'h310, 32'h311, 32'h0, 32'h0), 0, 1'b0, "f_b");
        cycle(4'hF, mk(32'h320, 32'h321, 32'h322, 32'h323), 2, 1'b1, "fprio");
        chk("fprio.cnt", 32'(bus.count), 32'd0);

        // Asynchronous reset between edges
        enq4(32'h400, "r_a");
        enq4(32'h404, "r_b");
        cycle(4'b0001, mk(32'h408, 32'h0, 32'h0, 32'h0), 0, 1'b0, "r_c");
        chk("r.cnt9", 32'(bus.count), 32'd9);
        bus.in_valid = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst.cnt", 32'(bus.count), 32'd0);
        chk("arst.rdy", 32'(bus.in_ready), 32'd1);
        chk("arst.empty", 32'(bus.empty), 32'd1);
        mdl.delete();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            cycle(4'($urandom_range(0, 15)),
                  mk($urandom, $urandom, $urandom, $urandom),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 31) == 0),
                  "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
